// File: rtl/dmem_arb_pkg.sv
// Shared constants and helpers for the data-memory arbiter.
package dmem_arb_pkg;

  // Requester identifiers, as reported on the owner output.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  localparam int DEF_ADDR_W   = 6;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_LOCK_MAX = 8;

  // Lock counter width: it must be able to hold LOCK_MAX itself.
  function automatic int lock_cnt_w(input int lock_max);
    return $clog2(lock_max + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select for the two-requester memory arbiter.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic prio_i,
  input  logic lock_ok_i,
  output logic gnt0_o,
  output logic gnt1_o,
  output logic winner_o
);

  // A lone requester always wins; under contention the lock or prio decides.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (req0_i && req1_i) begin
      if (lock_ok_i || (prio_i == REQ_DBG)) gnt1_o = 1'b1;
      else                                  gnt0_o = 1'b1;
    end else if (req0_i) begin
      gnt0_o = 1'b1;
    end else if (req1_i) begin
      gnt1_o = 1'b1;
    end
    // With no grant the winner reads as the CPU so the memory muxes idle on r0.
    winner_o = gnt1_o ? REQ_DBG : REQ_CPU;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// (requester 0) and the debug/loader port (requester 1), with bounded
// debug burst locking and a one-cycle read-valid return path.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  input  logic              r1_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  localparam int                CNT_W      = lock_cnt_w(LOCK_MAX);
  localparam logic [CNT_W-1:0]  LOCK_MAX_C = CNT_W'(LOCK_MAX);

  logic             prio_q, prio_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             rv0_q, rv0_d;
  logic             rv1_q, rv1_d;

  logic req0_v, req1_v, lock_ok;
  logic gnt0, gnt1, winner;

  // Nothing is issued while reset is held, even if requests are present.
  assign req0_v  = r0_req & ~rst;
  assign req1_v  = r1_req & ~rst;
  assign lock_ok = r1_lock && (last_q == REQ_DBG) && (lock_cnt_q < LOCK_MAX_C);

  dmem_arb_pick u_pick (
    .req0_i    (req0_v),
    .req1_i    (req1_v),
    .prio_i    (prio_q),
    .lock_ok_i (lock_ok),
    .gnt0_o    (gnt0),
    .gnt1_o    (gnt1),
    .winner_o  (winner)
  );

  assign r0_gnt = gnt0;
  assign r1_gnt = gnt1;
  assign mem_en = gnt0 | gnt1;
  assign owner  = last_q;

  // Route the winner's access fields to the memory; r0 when idle.
  always_comb begin
    mem_we    = r0_we;
    mem_addr  = r0_addr;
    mem_wdata = r0_wdata;
    if (winner == REQ_DBG) begin
      mem_we    = r1_we;
      mem_addr  = r1_addr;
      mem_wdata = r1_wdata;
    end
  end

  // Next-state for priority, owner, lock counter and read-valid flags.
  always_comb begin
    prio_d     = prio_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    if (mem_en) begin
      last_d = winner;
      prio_d = ~winner;
    end
    if (gnt0 || !r1_lock) begin
      lock_cnt_d = '0;
    end else if (gnt1 && r0_req && (lock_cnt_q < LOCK_MAX_C)) begin
      lock_cnt_d = lock_cnt_q + 1'b1;
    end
    rv0_d = gnt0 & ~r0_we;
    rv1_d = gnt1 & ~r1_we;
  end

  // State registers with synchronous reset; r0 is favoured on restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state is written with non-blocking assignments only.
      prio_q     <= REQ_CPU;
      last_q     <= REQ_CPU;
      lock_cnt_q <= '0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rv0_q      <= rv0_d;
      rv1_q      <= rv1_d;
    end
  end

  // A read issued just before reset is squashed in the reset cycle itself,
  // so the requester never sees a pulse for an access reset abandoned.
  assign r0_rvalid = rv0_q & ~rst;
  assign r1_rvalid = rv1_q & ~rst;
  assign r0_rdata  = r0_rvalid ? mem_rdata : '0;
  assign r1_rdata  = r1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table-driven single-cycle vectors
// plus hand-written lock-burst and reset-mid-read sequences.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_we, r1_req, r1_we, r1_lock;
  logic [5:0]  r0_addr, r1_addr;
  logic [15:0] r0_wdata, r1_wdata;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [15:0] r0_rdata, r1_rdata;
  logic        mem_en, mem_we, owner;
  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .r0_req    (r0_req),
    .r0_we     (r0_we),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r0_gnt    (r0_gnt),
    .r0_rvalid (r0_rvalid),
    .r0_rdata  (r0_rdata),
    .r1_req    (r1_req),
    .r1_we     (r1_we),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_gnt    (r1_gnt),
    .r1_rvalid (r1_rvalid),
    .r1_rdata  (r1_rdata),
    .r1_lock   (r1_lock),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .owner     (owner)
  );

  // Synchronous-read 64x16 data memory model, preloaded with 16'hA000 + addr.
  logic [15:0] mem [64];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  typedef struct {
    logic        rst;
    logic        r0_req;
    logic        r0_we;
    logic [5:0]  r0_addr;
    logic [15:0] r0_wdata;
    logic        r1_req;
    logic        r1_we;
    logic [5:0]  r1_addr;
    logic [15:0] r1_wdata;
    logic        r1_lock;
    logic        e_g0;
    logic        e_g1;
    logic        e_rv0;
    logic [15:0] e_rd0;
    logic        e_rv1;
    logic [15:0] e_rd1;
    logic        e_en;
    logic [5:0]  e_addr;
    logic        e_owner;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge and check outputs before the next rise.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    rst      = v.rst;
    r0_req   = v.r0_req;   r0_we = v.r0_we;   r0_addr = v.r0_addr;   r0_wdata = v.r0_wdata;
    r1_req   = v.r1_req;   r1_we = v.r1_we;   r1_addr = v.r1_addr;   r1_wdata = v.r1_wdata;
    r1_lock  = v.r1_lock;
    #1;
    check({tag, ".r0_gnt"},    32'(r0_gnt),    32'(v.e_g0));
    check({tag, ".r1_gnt"},    32'(r1_gnt),    32'(v.e_g1));
    check({tag, ".r0_rvalid"}, 32'(r0_rvalid), 32'(v.e_rv0));
    check({tag, ".r0_rdata"},  32'(r0_rdata),  32'(v.e_rd0));
    check({tag, ".r1_rvalid"}, 32'(r1_rvalid), 32'(v.e_rv1));
    check({tag, ".r1_rdata"},  32'(r1_rdata),  32'(v.e_rd1));
    check({tag, ".mem_en"},    32'(mem_en),    32'(v.e_en));
    check({tag, ".mem_addr"},  32'(mem_addr),  32'(v.e_addr));
    check({tag, ".owner"},     32'(owner),     32'(v.e_owner));
    if (r0_gnt && r1_gnt) check({tag, ".one_hot_gnt"}, 32'd1, 32'd0);
  endtask

  vec_t tbl [20];
  vec_t v;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);
    rst = 1'b1;
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0; r1_lock = 0;
    repeat (2) @(posedge clk);

    //          rst r0:req we addr wdata      r1:req we addr wdata  lock | g0 g1 rv0 rd0       rv1 rd1       en addr own
    // Reset holds off a pending r0 request; then r0 write/read of addr 5.
    tbl[0]  = '{1, 1,0, 6'd3, 16'h0000,      0,0,6'd0, 16'h0, 0,   0,0, 0,16'h0000, 0,16'h0000, 0,6'd3, 0};
    tbl[1]  = '{0, 1,1, 6'd5, 16'hBEEF,      0,0,6'd0, 16'h0, 0,   1,0, 0,16'h0000, 0,16'h0000, 1,6'd5, 0};
    tbl[2]  = '{0, 1,0, 6'd5, 16'h0000,      0,0,6'd0, 16'h0, 0,   1,0, 0,16'h0000, 0,16'h0000, 1,6'd5, 0};
    tbl[3]  = '{0, 0,0, 6'd0, 16'h0000,      0,0,6'd0, 16'h0, 0,   0,0, 1,16'hBEEF, 0,16'h0000, 0,6'd0, 0};
    tbl[4]  = '{0, 0,0, 6'd0, 16'h0000,      0,0,6'd0, 16'h0, 0,   0,0, 0,16'h0000, 0,16'h0000, 0,6'd0, 0};
    // After reset (prio=0) a lone r1 request wins at once; then r1 read / r0 write of addr 2.
    tbl[5]  = '{1, 0,0, 6'd0, 16'h0000,      0,0,6'd0, 16'h0, 0,   0,0, 0,16'h0000, 0,16'h0000, 0,6'd0, 0};
    tbl[6]  = '{0, 0,0, 6'd0, 16'h0000,      1,0,6'd9, 16'h0, 0,   0,1, 0,16'h0000, 0,16'h0000, 1,6'd9, 0};
    tbl[7]  = '{0, 0,0, 6'd0, 16'h0000,      0,0,6'd0, 16'h0, 0,   0,0, 0,16'h0000, 1,16'hA009, 0,6'd0, 1};
    tbl[8]  = '{0, 0,0, 6'd0, 16'h0000,      1,0,6'd2, 16'h0, 0,   0,1, 0,16'h0000, 0,16'h0000, 1,6'd2, 1};
    tbl[9]  = '{0, 1,1, 6'd2, 16'h0042,      0,0,6'd0, 16'h0, 0,   1,0, 0,16'h0000, 1,16'hA002, 1,6'd2, 1};
    tbl[10] = '{0, 1,0, 6'd2, 16'h0000,      0,0,6'd0, 16'h0, 0,   1,0, 0,16'h0000, 0,16'h0000, 1,6'd2, 0};
    tbl[11] = '{0, 0,0, 6'd0, 16'h0000,      0,0,6'd0, 16'h0, 0,   0,0, 1,16'h0042, 0,16'h0000, 0,6'd0, 0};
    // Both reading with no lock: strict alternation starting with r0.
    tbl[12] = '{1, 0,0, 6'd0, 16'h0000,      0,0,6'd0, 16'h0, 0,   0,0, 0,16'h0000, 0,16'h0000, 0,6'd0, 0};
    tbl[13] = '{0, 1,0, 6'd10,16'h0000,      1,0,6'd11,16'h0, 0,   1,0, 0,16'h0000, 0,16'h0000, 1,6'd10,0};
    tbl[14] = '{0, 1,0, 6'd10,16'h0000,      1,0,6'd11,16'h0, 0,   0,1, 1,16'hA00A, 0,16'h0000, 1,6'd11,0};
    tbl[15] = '{0, 1,0, 6'd10,16'h0000,      1,0,6'd11,16'h0, 0,   1,0, 0,16'h0000, 1,16'hA00B, 1,6'd10,1};
    tbl[16] = '{0, 1,0, 6'd10,16'h0000,      1,0,6'd11,16'h0, 0,   0,1, 1,16'hA00A, 0,16'h0000, 1,6'd11,0};
    tbl[17] = '{0, 1,0, 6'd10,16'h0000,      1,0,6'd11,16'h0, 0,   1,0, 0,16'h0000, 1,16'hA00B, 1,6'd10,1};
    tbl[18] = '{0, 1,0, 6'd10,16'h0000,      1,0,6'd11,16'h0, 0,   0,1, 1,16'hA00A, 0,16'h0000, 1,6'd11,0};
    tbl[19] = '{0, 0,0, 6'd0, 16'h0000,      0,0,6'd0, 16'h0, 0,   0,0, 0,16'h0000, 1,16'hA00B, 0,6'd0, 1};

    for (int i = 0; i < 20; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset mid-read: r0 read granted, rst next cycle squashes the rvalid.
    v = '{0, 1,0,6'd7,16'h0, 0,0,6'd0,16'h0, 0,  1,0, 0,16'h0, 0,16'h0, 1,6'd7, 1};
    run_vec(v, "rstmid.grant");
    v = '{1, 1,0,6'd7,16'h0, 0,0,6'd0,16'h0, 0,  0,0, 0,16'h0, 0,16'h0, 0,6'd7, 0};
    run_vec(v, "rstmid.in_rst");
    v = '{0, 1,0,6'd7,16'h0, 1,0,6'd8,16'h0, 0,  1,0, 0,16'h0, 0,16'h0, 1,6'd7, 0};
    run_vec(v, "rstmid.first");
    v = '{0, 0,0,6'd0,16'h0, 0,0,6'd0,16'h0, 0,  0,0, 1,16'hA007, 0,16'h0, 0,6'd0, 0};
    run_vec(v, "rstmid.rdata");

    // Lock burst: r0, then 8 r1 grants, then r0 forced once, then the burst repeats.
    v = '{1, 0,0,6'd0,16'h0, 0,0,6'd0,16'h0, 0,  0,0, 0,16'h0, 0,16'h0, 0,6'd0, 0};
    run_vec(v, "lock.rst");
    for (int i = 0; i < 19; i++) begin
      logic exp_g0, prev_g0;
      exp_g0  = ((i % 9) == 0);
      prev_g0 = (((i - 1) % 9) == 0);
      v = '{0, 1,1,6'd20,16'h0001, 1,1,6'd21,16'h0002, 1,
            exp_g0, !exp_g0, 0,16'h0, 0,16'h0, 1, exp_g0 ? 6'd20 : 6'd21,
            (i == 0) ? 1'b0 : !prev_g0};
      run_vec(v, $sformatf("lock%0d", i));
    end
    v = '{0, 0,0,6'd0,16'h0, 0,0,6'd0,16'h0, 0,  0,0, 0,16'h0, 0,16'h0, 0,6'd0, 0};
    run_vec(v, "lock.idle");
    check("lock.mem20", 32'(mem[20]), 32'h0001);
    check("lock.mem21", 32'(mem[21]), 32'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
